// File: rtl/shift_arbiter_if.sv
// Command/response bundle for shift_arbiter: two requester ports (A, B) and the shared result bus.
// master = requester side, slave = arbiter side.
interface shift_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             A_valid;
  logic             A_ready;
  logic [31:0]      A_data;
  logic [4:0]       A_count;
  logic [1:0]       A_sel;
  logic [TAG_W-1:0] A_tag;
  logic             B_valid;
  logic             B_ready;
  logic [31:0]      B_data;
  logic [4:0]       B_count;
  logic [1:0]       B_sel;
  logic [TAG_W-1:0] B_tag;
  logic             A_rsp_valid;
  logic             A_rsp_ready;
  logic             B_rsp_valid;
  logic             B_rsp_ready;
  logic [31:0]      Rsp_data;
  logic [TAG_W-1:0] Rsp_tag;

  modport master (
    output A_valid, A_data, A_count, A_sel, A_tag,
    output B_valid, B_data, B_count, B_sel, B_tag,
    output A_rsp_ready, B_rsp_ready,
    input  A_ready, B_ready, A_rsp_valid, B_rsp_valid, Rsp_data, Rsp_tag
  );

  modport slave (
    input  A_valid, A_data, A_count, A_sel, A_tag,
    input  B_valid, B_data, B_count, B_sel, B_tag,
    input  A_rsp_ready, B_rsp_ready,
    output A_ready, B_ready, A_rsp_valid, B_rsp_valid, Rsp_data, Rsp_tag
  );
endinterface

// File: rtl/shift_arbiter.sv
// Shares one 32-bit barrel shifter between ports A and B with a one-deep tagged result stage.
// Define SHIFT_ARB_RR_EN for round-robin tie-breaking; otherwise A has fixed priority.
module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  shift_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             owner_reg;
  logic [31:0]      data_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             out_valid, pop, space, accept, grant_b, tie_b;
  logic [31:0]      cmd_data, shift_res;
  logic [4:0]       cmd_count;
  logic [1:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  logic [63:0]      rot;

`ifdef SHIFT_ARB_RR_EN
  logic last_grant_reg;  // 0 = A, 1 = B

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      last_grant_reg <= 1'b1;
    else if (accept)
      last_grant_reg <= grant_b;
  end

  assign tie_b = ~last_grant_reg;
`else
  assign tie_b = 1'b0;
`endif

  assign out_valid = (state_reg == FULL);
  assign pop       = out_valid & (owner_reg ? bus.B_rsp_ready : bus.A_rsp_ready);
  assign space     = ~out_valid | pop;
  assign accept    = space & (bus.A_valid | bus.B_valid);

  always_comb begin
    grant_b = 1'b0;
    if (bus.B_valid && !bus.A_valid)
      grant_b = 1'b1;
    else if (bus.A_valid && bus.B_valid)
      grant_b = tie_b;
  end

  // The granted command steers the single shifter.
  always_comb begin
    cmd_data  = grant_b ? bus.B_data  : bus.A_data;
    cmd_count = grant_b ? bus.B_count : bus.A_count;
    cmd_sel   = grant_b ? bus.B_sel   : bus.A_sel;
    cmd_tag   = grant_b ? bus.B_tag   : bus.A_tag;
    rot       = {cmd_data, cmd_data} >> cmd_count;
    shift_res = cmd_data;
    case (cmd_sel)
      2'b00:   shift_res = cmd_data << cmd_count;
      2'b01:   shift_res = cmd_data >> cmd_count;
      2'b10:   shift_res = rot[31:0];
      default: shift_res = $signed(cmd_data) >>> cmd_count;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= EMPTY;
      owner_reg <= 1'b0;
      data_reg  <= '0;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg <= grant_b;
        data_reg  <= shift_res;
        tag_reg   <= cmd_tag;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      default: if (pop && !accept) state_next = EMPTY;
    endcase
  end

  // Ready is forced low while reset is held, even though the stage is empty.
  always_comb begin
    bus.A_ready     = Reset_n & space & ~grant_b;
    bus.B_ready     = Reset_n & space & grant_b;
    bus.A_rsp_valid = out_valid & ~owner_reg;
    bus.B_rsp_valid = out_valid & owner_reg;
    bus.Rsp_data    = data_reg;
    bus.Rsp_tag     = tag_reg;
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter; expectations honour SHIFT_ARB_RR_EN when defined.
module tb_shift_arbiter;
  localparam int TAG_W = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  shift_arbiter_if #(.TAG_W(TAG_W)) bus ();

  shift_arbiter #(.TAG_W(TAG_W)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.A_valid = 0; bus.A_data = '0; bus.A_count = '0; bus.A_sel = '0; bus.A_tag = '0;
    bus.B_valid = 0; bus.B_data = '0; bus.B_count = '0; bus.B_sel = '0; bus.B_tag = '0;
    bus.A_rsp_ready = 0; bus.B_rsp_ready = 0;
  endtask

  task automatic drive_a(input logic [31:0] d, input logic [1:0] s, input logic [4:0] c,
                         input logic [TAG_W-1:0] t);
    bus.A_valid = 1; bus.A_data = d; bus.A_sel = s; bus.A_count = c; bus.A_tag = t;
  endtask

  task automatic drive_b(input logic [31:0] d, input logic [1:0] s, input logic [4:0] c,
                         input logic [TAG_W-1:0] t);
    bus.B_valid = 1; bus.B_data = d; bus.B_sel = s; bus.B_count = c; bus.B_tag = t;
  endtask

  task automatic do_reset;
    idle_inputs();
    Reset_n = 0;
    step();
    step();
    Reset_n = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.A_valid = 1;
    bus.B_valid = 1;
    Reset_n = 0;
    step();
    vectors++; if (bus.A_ready !== 1'b0) begin miscompares++; $display("FAIL reset_a_ready: got %b want 0", bus.A_ready); end
    vectors++; if (bus.B_ready !== 1'b0) begin miscompares++; $display("FAIL reset_b_ready: got %b want 0", bus.B_ready); end
    vectors++; if (bus.A_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_rsp_valid: got %b want 0", bus.A_rsp_valid); end
    vectors++; if (bus.B_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_rsp_valid: got %b want 0", bus.B_rsp_valid); end
    vectors++; if (bus.Rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", bus.Rsp_data); end
    vectors++; if (bus.Rsp_tag !== 4'h0) begin miscompares++; $display("FAIL reset_rsp_tag: got %h want 0", bus.Rsp_tag); end
    $display("reset: ready=%b/%b rsp_valid=%b/%b", bus.A_ready, bus.B_ready, bus.A_rsp_valid, bus.B_rsp_valid);
    idle_inputs();
    Reset_n = 1;
    step();
  endtask

  task automatic test_single_a;
    bus.A_rsp_ready = 1;
    drive_a(32'h80000001, 2'b11, 5'd4, 4'h2);
    #1;
    vectors++; if (bus.A_ready !== 1'b1) begin miscompares++; $display("FAIL single_a_ready: got %b want 1", bus.A_ready); end
    vectors++; if (bus.B_ready !== 1'b0) begin miscompares++; $display("FAIL single_b_ready: got %b want 0", bus.B_ready); end
    step();
    bus.A_valid = 0;
    vectors++; if (bus.A_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_a_rsp_valid: got %b want 1", bus.A_rsp_valid); end
    vectors++; if (bus.B_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_b_rsp_valid: got %b want 0", bus.B_rsp_valid); end
    vectors++; if (bus.Rsp_data !== 32'hF8000000) begin miscompares++; $display("FAIL single_sra_data: got %h want f8000000", bus.Rsp_data); end
    vectors++; if (bus.Rsp_tag !== 4'h2) begin miscompares++; $display("FAIL single_tag: got %h want 2", bus.Rsp_tag); end
    $display("A SRA 80000001>>>4 -> %h tag %h", bus.Rsp_data, bus.Rsp_tag);
    step();
    vectors++; if (bus.A_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop: got %b want 0", bus.A_rsp_valid); end
  endtask

  task automatic test_shift_ops;
    logic [31:0] d [8];
    logic [1:0]  s [8];
    logic [4:0]  c [8];
    logic [3:0]  t [8];
    logic [31:0] e [8];
    d = '{32'h80000001, 32'h00000001, 32'h80000000, 32'h80000001,
          32'h87654321, 32'h87654321, 32'h87654321, 32'h87654321};
    s = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    c = '{5'd4, 5'd31, 5'd1, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    t = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8};
    e = '{32'h18000000, 32'h80000000, 32'h40000000, 32'h08000000,
          32'h87654321, 32'h87654321, 32'h87654321, 32'h87654321};
    bus.B_rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive_b(d[i], s[i], c[i], t[i]);
      #1;
      vectors++; if (bus.B_ready !== 1'b1) begin miscompares++; $display("FAIL ops%0d_b_ready: got %b want 1", i, bus.B_ready); end
      step();
      bus.B_valid = 0;
      vectors++; if (bus.B_rsp_valid !== 1'b1 || bus.A_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ops%0d_owner: got a=%b b=%b want a=0 b=1", i, bus.A_rsp_valid, bus.B_rsp_valid); end
      vectors++; if (bus.Rsp_data !== e[i]) begin miscompares++; $display("FAIL ops%0d_data: got %h want %h", i, bus.Rsp_data, e[i]); end
      vectors++; if (bus.Rsp_tag !== t[i]) begin miscompares++; $display("FAIL ops%0d_tag: got %h want %h", i, bus.Rsp_tag, t[i]); end
      $display("B sel=%0d %h by %0d -> %h tag %h", s[i], d[i], c[i], bus.Rsp_data, bus.Rsp_tag);
      step();
    end
  endtask

  task automatic test_tie;
    logic exp [4];
`ifdef SHIFT_ARB_RR_EN
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    bus.A_rsp_ready = 1;
    bus.B_rsp_ready = 1;
    drive_a(32'h0000000F, 2'b00, 5'd4, 4'h1);
    drive_b(32'hF0000000, 2'b01, 5'd4, 4'h9);
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.A_ready !== ~exp[i] || bus.B_ready !== exp[i]) begin miscompares++; $display("FAIL tie%0d_ready: got a=%b b=%b want a=%b b=%b", i, bus.A_ready, bus.B_ready, ~exp[i], exp[i]); end
      step();
      vectors++; if (bus.A_rsp_valid !== ~exp[i] || bus.B_rsp_valid !== exp[i]) begin miscompares++; $display("FAIL tie%0d_owner: got a=%b b=%b want b=%b", i, bus.A_rsp_valid, bus.B_rsp_valid, exp[i]); end
      vectors++; if (bus.Rsp_data !== (exp[i] ? 32'h0F000000 : 32'h000000F0)) begin miscompares++; $display("FAIL tie%0d_data: got %h", i, bus.Rsp_data); end
      vectors++; if (bus.Rsp_tag !== (exp[i] ? 4'h9 : 4'h1)) begin miscompares++; $display("FAIL tie%0d_tag: got %h", i, bus.Rsp_tag); end
      $display("tie %0d granted %s data %h", i, bus.B_rsp_valid ? "B" : "A", bus.Rsp_data);
    end
    bus.A_valid = 0;
    bus.B_valid = 0;
    step();
  endtask

  task automatic test_stall;
    bus.A_rsp_ready = 0;
    bus.B_rsp_ready = 1;
    drive_a(32'h12345678, 2'b01, 5'd8, 4'h3);
    #1;
    step();
    bus.A_valid = 0;
    drive_b(32'h00000001, 2'b00, 5'd4, 4'hA);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.A_ready !== 1'b0 || bus.B_ready !== 1'b0) begin miscompares++; $display("FAIL stall%0d_ready: got a=%b b=%b want 0 0", i, bus.A_ready, bus.B_ready); end
      vectors++; if (bus.A_rsp_valid !== 1'b1 || bus.Rsp_data !== 32'h00123456) begin miscompares++; $display("FAIL stall%0d_hold: got v=%b d=%h want 1 00123456", i, bus.A_rsp_valid, bus.Rsp_data); end
      $display("stall cycle %0d held %h", i, bus.Rsp_data);
      step();
    end
    bus.A_rsp_ready = 1;
    #1;
    vectors++; if (bus.B_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_b_ready: got %b want 1", bus.B_ready); end
    step();
    bus.B_valid = 0;
    vectors++; if (bus.B_rsp_valid !== 1'b1 || bus.A_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release_owner: got a=%b b=%b want 0 1", bus.A_rsp_valid, bus.B_rsp_valid); end
    vectors++; if (bus.Rsp_data !== 32'h00000010 || bus.Rsp_tag !== 4'hA) begin miscompares++; $display("FAIL stall_release_data: got %h/%h want 00000010/a", bus.Rsp_data, bus.Rsp_tag); end
    $display("stall released, B result %h tag %h", bus.Rsp_data, bus.Rsp_tag);
    step();
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    bus.A_rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive_a(32'(i + 1), 2'b00, 5'(i), 4'(i));
      #1;
      vectors++; if (bus.A_ready !== 1'b1) begin miscompares++; $display("FAIL b2b%0d_ready: got %b want 1", i, bus.A_ready); end
      step();
      e = 32'(i + 1) << i;
      vectors++; if (bus.A_rsp_valid !== 1'b1 || bus.Rsp_data !== e || bus.Rsp_tag !== 4'(i)) begin miscompares++; $display("FAIL b2b%0d_result: got v=%b d=%h t=%h want 1 %h %h", i, bus.A_rsp_valid, bus.Rsp_data, bus.Rsp_tag, e, 4'(i)); end
      $display("b2b %0d result %h", i, bus.Rsp_data);
    end
    bus.A_valid = 0;
    step();
    vectors++; if (bus.A_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", bus.A_rsp_valid); end
  endtask

  task automatic test_async_reset;
    bus.A_rsp_ready = 0;
    drive_a(32'hDEADBEEF, 2'b00, 5'd0, 4'hC);
    #1;
    step();
    bus.A_valid = 0;
    vectors++; if (bus.A_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL areset_held: got %b want 1", bus.A_rsp_valid); end
    #2;
    Reset_n = 0;
    #1;
    vectors++; if (bus.A_rsp_valid !== 1'b0 || bus.Rsp_data !== 32'h0) begin miscompares++; $display("FAIL areset_async_clear: got v=%b d=%h want 0 0", bus.A_rsp_valid, bus.Rsp_data); end
    $display("async reset: rsp_valid=%b data=%h", bus.A_rsp_valid, bus.Rsp_data);
    step();
    Reset_n = 1;
    bus.A_rsp_ready = 1;
    bus.B_rsp_ready = 1;
    drive_a(32'h00000003, 2'b00, 5'd1, 4'h4);
    drive_b(32'h00000003, 2'b00, 5'd2, 4'h8);
    #1;
    vectors++; if (bus.A_ready !== 1'b1 || bus.B_ready !== 1'b0) begin miscompares++; $display("FAIL areset_first_tie: got a=%b b=%b want 1 0", bus.A_ready, bus.B_ready); end
    step();
    bus.A_valid = 0;
    bus.B_valid = 0;
    vectors++; if (bus.A_rsp_valid !== 1'b1 || bus.Rsp_data !== 32'h6 || bus.Rsp_tag !== 4'h4) begin miscompares++; $display("FAIL areset_first_result: got v=%b d=%h t=%h want 1 6 4", bus.A_rsp_valid, bus.Rsp_data, bus.Rsp_tag); end
    $display("post-reset tie granted %s data %h", bus.A_rsp_valid ? "A" : "B", bus.Rsp_data);
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_a();
    test_shift_ops();
    test_tie();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
